// File: rtl/spi_ram_hs_if.sv
// ---------------------------------------------------------------------------
// spi_ram_hs_if
//
// Parallel-side bus between an SPI slave and the spi_ram_hs word RAM.
//
// Signals:
//   rx_valid    master -> slave  din carries a command word this cycle
//   din         master -> slave  {cmd[1:0], payload[MEM_WIDTH-1:0]}
//   tx_ready    master -> slave  master accepts dout this cycle
//   dout        slave -> master  read data
//   tx_valid    slave -> master  dout valid, held until accepted
//   addr_err    slave -> master  one-cycle pulse, address command out of range
//   ovf_err     slave -> master  one-cycle pulse, read dropped while one pending
//   parity_err  slave -> master  one-cycle pulse, stored parity mismatch
//
// Modports:
//   master : the SPI slave (drives commands and tx_ready)
//   slave  : the RAM (drives read data and status)
// ---------------------------------------------------------------------------
interface spi_ram_hs_if #(
    parameter int MEM_WIDTH = 8
);
    logic                 rx_valid;
    logic [MEM_WIDTH+1:0] din;
    logic                 tx_ready;
    logic [MEM_WIDTH-1:0] dout;
    logic                 tx_valid;
    logic                 addr_err;
    logic                 ovf_err;
    logic                 parity_err;

    modport master (
        output rx_valid,
        output din,
        output tx_ready,
        input  dout,
        input  tx_valid,
        input  addr_err,
        input  ovf_err,
        input  parity_err
    );

    modport slave (
        input  rx_valid,
        input  din,
        input  tx_ready,
        output dout,
        output tx_valid,
        output addr_err,
        output ovf_err,
        output parity_err
    );
endinterface

// File: rtl/spi_ram_hs.sv
// ---------------------------------------------------------------------------
// spi_ram_hs
//
// Parametrised single-port word RAM sitting on the parallel side of an SPI
// slave. Each received word carries a 2-bit command in its top bits:
//   00 set write address   01 write data
//   10 set read address    11 read data
// Read data is returned through a tx_valid/tx_ready handshake so the SPI
// side can stall; a read issued while a previous one is still unaccepted is
// dropped and flagged with ovf_err.
//
// Parameters:
//   MEM_WIDTH  data word width (din is MEM_WIDTH+2 bits)
//   ADDR_SIZE  address field width, must be <= MEM_WIDTH
//   MEM_DEPTH  number of words, must be <= 2**ADDR_SIZE
//   AUTO_INC   1: write/read address post-increments (wrapping at
//              MEM_DEPTH-1) after each data access; 0: address held
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (memory contents are not reset)
//   bus    spi_ram_hs_if.slave (rx_valid, din, tx_ready in;
//          dout, tx_valid, addr_err, ovf_err, parity_err out)
//
// Optional feature (macro SPI_RAM_PARITY_EN):
//   Defined   - each word stores an extra even-parity bit written alongside
//               the data; a mismatch on read raises parity_err in the same
//               cycle tx_valid rises. parity_flip_hook inverts the stored
//               parity of a write when forced high from a test bench.
//   Undefined - no parity storage, parity_err tied to 0.
// ---------------------------------------------------------------------------
module spi_ram_hs #(
    parameter int MEM_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_ram_hs_if.slave  bus
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] CMD_SET_WR = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_SET_RD = 2'b10;
    localparam logic [1:0] CMD_READ   = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable and the
    // range check can never wrap.
    localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    // Array index width; addresses are range-checked before they are stored,
    // so dropping the upper address bits for indexing loses nothing.
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef SPI_RAM_PARITY_EN
    localparam int WORD_W = MEM_WIDTH + 1;
`else
    localparam int WORD_W = MEM_WIDTH;
`endif

    // -----------------------------------------------------------------------
    // Command decode
    // -----------------------------------------------------------------------
    logic [1:0]           cmd;
    logic [MEM_WIDTH-1:0] payload;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic                 addr_in_range;

    logic                 set_wr;
    logic                 wr_en;
    logic                 set_rd;
    logic                 rd_cmd;
    logic                 rd_accept;
    logic                 rd_drop;

    logic [0:0]           state_reg;
    logic [0:0]           state_next;
    logic [ADDR_SIZE-1:0] addr_wr_reg;
    logic [ADDR_SIZE-1:0] addr_wr_next;
    logic [ADDR_SIZE-1:0] addr_rd_reg;
    logic [ADDR_SIZE-1:0] addr_rd_next;

    assign cmd      = bus.din[MEM_WIDTH+1:MEM_WIDTH];
    assign payload  = bus.din[MEM_WIDTH-1:0];
    assign cmd_addr = payload[ADDR_SIZE-1:0];

    assign addr_in_range = ({1'b0, cmd_addr} < DEPTH_EXT);

    assign set_wr = bus.rx_valid && (cmd == CMD_SET_WR);
    assign wr_en  = bus.rx_valid && (cmd == CMD_WRITE);
    assign set_rd = bus.rx_valid && (cmd == CMD_SET_RD);
    assign rd_cmd = bus.rx_valid && (cmd == CMD_READ);

    // A read can be taken when nothing is pending, or when the pending word
    // is being consumed in this very cycle (back-to-back, no bubble).
    assign rd_accept = rd_cmd && ((state_reg == ST_IDLE) || bus.tx_ready);
    assign rd_drop   = rd_cmd && !((state_reg == ST_IDLE) || bus.tx_ready);

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        addr_wr_next = addr_wr_reg;
        if (set_wr && addr_in_range) begin
            addr_wr_next = cmd_addr;
        end else if (wr_en && (AUTO_INC != 0)) begin
            addr_wr_next = next_addr(addr_wr_reg);
        end
    end

    always_comb begin
        addr_rd_next = addr_rd_reg;
        if (set_rd && addr_in_range) begin
            addr_rd_next = cmd_addr;
        end else if (rd_accept && (AUTO_INC != 0)) begin
            addr_rd_next = next_addr(addr_rd_reg);
        end
    end

    always_comb begin
        state_next = state_reg;
        if (rd_accept) begin
            state_next = ST_HOLD;
        end else if ((state_reg == ST_HOLD) && bus.tx_ready) begin
            state_next = ST_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    logic addr_err_reg;
    logic ovf_err_reg;
    logic has_data_reg;     // a word has been read since reset
    logic parity_chk_reg;   // rd_word_reg was loaded on the previous edge

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            addr_wr_reg    <= '0;
            addr_rd_reg    <= '0;
            addr_err_reg   <= 1'b0;
            ovf_err_reg    <= 1'b0;
            has_data_reg   <= 1'b0;
            parity_chk_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_wr_reg    <= addr_wr_next;
            addr_rd_reg    <= addr_rd_next;
            addr_err_reg   <= (set_wr || set_rd) && !addr_in_range;
            ovf_err_reg    <= rd_drop;
            parity_chk_reg <= rd_accept;
            if (rd_accept) begin
                has_data_reg <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Memory array
    //
    // The read register has no reset so the array plus register maps onto a
    // block RAM with registered output. The reset value of dout is produced
    // by masking with has_data_reg instead. The register only loads on an
    // accepted read, so it holds the captured word through HOLD even if that
    // address is rewritten meanwhile.
    // -----------------------------------------------------------------------
    logic [WORD_W-1:0]    mem [0:MEM_DEPTH-1];
    logic [WORD_W-1:0]    wr_word;
    logic [WORD_W-1:0]    rd_word_reg;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;

    assign wr_idx = addr_wr_reg[IDX_W-1:0];
    assign rd_idx = addr_rd_reg[IDX_W-1:0];

`ifdef SPI_RAM_PARITY_EN
    // Test hook: held at 0 in normal operation, forced high by a bench to
    // store a deliberately wrong parity bit.
    logic parity_flip_hook;
    assign parity_flip_hook = 1'b0;

    // Even parity: data plus parity bit always carries an even number of ones.
    assign wr_word = {(^payload) ^ parity_flip_hook, payload};
`else
    assign wr_word = payload;
`endif

    // Only one command per cycle, so a write and a read never share a cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_word;
        end
        if (rd_accept) begin
            rd_word_reg <= mem[rd_idx];
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.dout     = has_data_reg ? rd_word_reg[MEM_WIDTH-1:0] : '0;
    assign bus.tx_valid = (state_reg == ST_HOLD);
    assign bus.addr_err = addr_err_reg;
    assign bus.ovf_err  = ovf_err_reg;

`ifdef SPI_RAM_PARITY_EN
    // Checked only in the cycle right after a load, which is the cycle
    // tx_valid rises (or a back-to-back word replaces the previous one).
    assign bus.parity_err = parity_chk_reg && (^rd_word_reg);
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/spi_ram_hs.md
Name: spi_ram_hs

Overview:
- Parametrised single-port RAM slave for the SPI slave's parallel side; next generation of the fixed 8-bit/256-word SPI RAM.
- Decodes the same 2-bit command field prepended to each received word: 00 set write address, 01 write data, 10 set read address, 11 read data.
- Adds width, depth and address-size generics, optional address auto-increment, and address range checking.
- Adds a tx_valid/tx_ready output handshake so the SPI slave can stall read data.

Parameters:
- MEM_WIDTH, 8, data word width in bits; din is MEM_WIDTH+2 bits wide.
- ADDR_SIZE, 8, address width in bits; must satisfy ADDR_SIZE <= MEM_WIDTH.
- MEM_DEPTH, 256, number of words; must satisfy MEM_DEPTH <= 2**ADDR_SIZE.
- AUTO_INC, 1, 1 = the address post-increments after each data write or data read; 0 = the address is held.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  din carries a valid command word this cycle.
- din  in  MEM_WIDTH+2  [MEM_WIDTH+1:MEM_WIDTH] = command; [MEM_WIDTH-1:0] = payload; the address is payload[ADDR_SIZE-1:0].
- tx_ready  in  1  consumer accepts dout this cycle.
- dout  out  MEM_WIDTH  read data.
- tx_valid  out  1  dout is valid; held until accepted.
- addr_err  out  1  one-cycle pulse: an address command was out of range.
- ovf_err  out  1  one-cycle pulse: a read command was dropped because the previous read was still pending.
- parity_err  out  1  one-cycle pulse; tied to 0 unless SPI_RAM_PARITY_EN is defined.

Behaviour:
- Reset (asynchronous, with rst_n low):
  - dout=0, tx_valid=0, addr_err=0, ovf_err=0, parity_err=0.
  - Internal addr_wr=0, addr_rd=0, state=IDLE.
  - Memory contents are not reset.
- Commands are sampled only when rx_valid=1. One memory access per cycle (single port).
- Cmd 00: addr_wr <= address at the next edge.
  - If address >= MEM_DEPTH: addr_wr is unchanged and addr_err=1 for the next cycle.
- Cmd 01: mem[addr_wr] <= payload[MEM_WIDTH-1:0] at the next edge.
  - If AUTO_INC=1: addr_wr <= (addr_wr==MEM_DEPTH-1) ? 0 : addr_wr+1.
- Cmd 10: addr_rd <= address, with the same range check as cmd 00 (addr_err on out-of-range, addr_rd unchanged).
- Cmd 11, read (FSM states IDLE and HOLD):
  - Accepted when state=IDLE, or when state=HOLD and tx_ready=1 in the same cycle.
  - On accept: dout <= mem[addr_rd] and tx_valid=1 at the next edge (latency 1); state=HOLD. addr_rd auto-increments as in cmd 01 when AUTO_INC=1.
  - Not accepted (state=HOLD, tx_ready=0): command dropped, addr_rd unchanged, ovf_err=1 for the next cycle.
- HOLD state:
  - dout and tx_valid stay stable until tx_ready=1 is sampled.
  - On accept with no new read in that cycle: tx_valid=0 and state=IDLE at the next edge. dout keeps its last value.
  - Accept plus new read in the same cycle: tx_valid stays 1 and dout updates (back-to-back reads, no bubble).
- A write to addr_rd while in HOLD does not change the captured dout.
- rx_valid=0: no address or memory change. The handshake continues independently.
- Cmd bits are ignored when rx_valid=0, including 11.
- tx_ready while tx_valid=0 is ignored.
- Error pulses never last longer than one cycle per offending command.
- Reset mid-HOLD: tx_valid drops immediately (asynchronous); the pending data is lost.

Optional Feature:
- Macro SPI_RAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit computed on write.
  - On each read the parity is recomputed; a mismatch sets parity_err=1 in the same cycle tx_valid rises.
  - dout is still delivered.
  - A hidden test hook inverts the stored parity bit for the next write when bench-forced.
- Undefined: no parity storage; parity_err is constant 0.

Test Plan:
- Reset: hold rst_n=0, then release -> dout=0, tx_valid=0, all error outputs 0. Cmd 11 then returns mem[0].
- Write/read with AUTO_INC=1: cmd00 addr 0x10; cmd01 data 0xA5; cmd01 data 0x5A; cmd10 addr 0x10; cmd11 with tx_ready=1; cmd11 -> dout=0xA5 one cycle after the first cmd11, then dout=0x5A. addr_rd ends at 0x12.
- Wrap with MEM_DEPTH=16, ADDR_SIZE=4:
  - cmd00 addr 15; cmd01 0x11; cmd01 0x22 -> mem[15]=0x11, mem[0]=0x22.
  - cmd00 with address payload 0x1F -> the 4-bit address field is 0xF, which is in range, so no addr_err.
  - With ADDR_SIZE=5, cmd00 addr 0x10 -> addr_err pulses, addr_wr unchanged.
- Backpressure: cmd11 with tx_ready=0 for 5 cycles -> tx_valid and dout stable. A second cmd11 during the stall -> ovf_err pulses 1 cycle, addr_rd unchanged. Raise tx_ready -> tx_valid falls the next cycle.
- Back-to-back: cmd11 issued in the same cycle as tx_ready=1 while in HOLD -> tx_valid stays 1 and dout updates to the next word with no gap.
- Parity (macro defined): force a corrupted parity on the write of 0x3C to addr 2, then read addr 2 -> dout=0x3C, tx_valid=1 and parity_err=1 in the same cycle. Macro undefined: parity_err stays 0.
